// File: rtl/usb3_phy_pkg.sv
// Shared 8b/10b definitions: K-code byte values, running-disparity encodings,
// symbol width and the stage-1 register layout of the line encoder.
package usb3_phy_pkg;

  localparam int SYM_W = 10;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // A7 sub-block in its RD- form
  localparam logic [3:0] ALT7_RDN = 4'b0111;

  // Codes are stored in RD- form; sel* = complement under RD+, dis* = flips RD.
  typedef struct packed {
    logic [5:0] code6;
    logic       dis6;
    logic       sel6;
    logic [3:0] code4;
    logic       dis4;
    logic       sel4;
    logic       alt_neg;
    logic       alt_pos;
    logic       k_err;
    logic       valid;
  } enc_stage1_t;

  function automatic logic is_legal_k(input logic [7:0] byte_val);
    logic [4:0] x5;
    logic [2:0] y3;
    x5 = byte_val[4:0];
    y3 = byte_val[7:5];
    return (x5 == 5'd28) ||
           ((y3 == 3'd7) && ((x5 == 5'd23) || (x5 == 5'd27) ||
                             (x5 == 5'd29) || (x5 == 5'd30)));
  endfunction

endpackage

// File: rtl/enc8b10b_lut.sv
// Combinational 5b/6b and 3b/4b lookup. Produces RD- codes plus the flags
// stage 2 needs to pick polarity, apply the alternate-7 form and track RD.
module enc8b10b_lut
  import usb3_phy_pkg::*;
(
  input  logic [4:0] x5,
  input  logic [2:0] y3,
  input  logic       k_flag,
  output logic [5:0] code6,
  output logic       dis6,
  output logic       sel6,
  output logic [3:0] code4,
  output logic       dis4,
  output logic       sel4,
  output logic       alt_neg,
  output logic       alt_pos,
  output logic       k_legal
);

  always_comb begin
    k_legal = k_flag && is_legal_k({y3, x5});

    code6 = 6'b000000;
    case (x5)
      5'd0:  code6 = 6'b100111;
      5'd1:  code6 = 6'b011101;
      5'd2:  code6 = 6'b101101;
      5'd3:  code6 = 6'b110001;
      5'd4:  code6 = 6'b110101;
      5'd5:  code6 = 6'b101001;
      5'd6:  code6 = 6'b011001;
      5'd7:  code6 = 6'b111000;
      5'd8:  code6 = 6'b111001;
      5'd9:  code6 = 6'b100101;
      5'd10: code6 = 6'b010101;
      5'd11: code6 = 6'b110100;
      5'd12: code6 = 6'b001101;
      5'd13: code6 = 6'b101100;
      5'd14: code6 = 6'b011100;
      5'd15: code6 = 6'b010111;
      5'd16: code6 = 6'b011011;
      5'd17: code6 = 6'b100011;
      5'd18: code6 = 6'b010011;
      5'd19: code6 = 6'b110010;
      5'd20: code6 = 6'b001011;
      5'd21: code6 = 6'b101010;
      5'd22: code6 = 6'b011010;
      5'd23: code6 = 6'b111010;
      5'd24: code6 = 6'b110011;
      5'd25: code6 = 6'b100110;
      5'd26: code6 = 6'b010110;
      5'd27: code6 = 6'b110110;
      5'd28: code6 = 6'b001110;
      5'd29: code6 = 6'b101110;
      5'd30: code6 = 6'b011110;
      default: code6 = 6'b101011;
    endcase
    if (k_legal && (x5 == 5'd28)) begin
      code6 = 6'b001111;
    end

    code4 = 4'b0000;
    if (k_legal) begin
      // K28.x has its own 3b/4b set; the other legal K codes are all .7 (A7 form)
      if (x5 == 5'd28) begin
        case (y3)
          3'd0:    code4 = 4'b1011;
          3'd1:    code4 = 4'b0110;
          3'd2:    code4 = 4'b1010;
          3'd3:    code4 = 4'b1100;
          3'd4:    code4 = 4'b1101;
          3'd5:    code4 = 4'b0101;
          3'd6:    code4 = 4'b1001;
          default: code4 = ALT7_RDN;
        endcase
      end else begin
        code4 = ALT7_RDN;
      end
    end else begin
      case (y3)
        3'd0:    code4 = 4'b1011;
        3'd1:    code4 = 4'b1001;
        3'd2:    code4 = 4'b0101;
        3'd3:    code4 = 4'b1100;
        3'd4:    code4 = 4'b1101;
        3'd5:    code4 = 4'b1010;
        3'd6:    code4 = 4'b0110;
        default: code4 = 4'b1110;
      endcase
    end

    dis6 = ($countones(code6) != 3);
    sel6 = dis6 || (code6 == 6'b111000);
    dis4 = ($countones(code4) != 2);
    sel4 = dis4 || (code4 == 4'b1100) || k_legal;

    // A7 avoids a run of five identical bits across the 6b/4b boundary
    alt_neg = !k_legal && (y3 == 3'd7) &&
              ((x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20));
    alt_pos = !k_legal && (y3 == 3'd7) &&
              ((x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14));
  end

endmodule

// File: rtl/encoder_8b10b.sv
// Two-stage 8b/10b line encoder with running-disparity tracking.
// Optional k_err_cnt statistics port enabled by defining ENC8B10B_STATS_EN.
module encoder_8b10b
  import usb3_phy_pkg::*;
#(
  parameter logic INIT_RD = RD_NEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             is_control,
  input  logic             data_valid,
  output logic [SYM_W-1:0] symbol,
  output logic             symbol_valid,
  output logic             rd_out,
  output logic             k_err
`ifdef ENC8B10B_STATS_EN
  , output logic [15:0]    k_err_cnt
`endif
);

  enc_stage1_t s1_reg;
  enc_stage1_t s1_next;

  logic [5:0] lut_code6;
  logic       lut_dis6;
  logic       lut_sel6;
  logic [3:0] lut_code4;
  logic       lut_dis4;
  logic       lut_sel4;
  logic       lut_alt_neg;
  logic       lut_alt_pos;
  logic       lut_k_legal;

  enc8b10b_lut u_lut (
    .x5      (data_in[4:0]),
    .y3      (data_in[7:5]),
    .k_flag  (is_control),
    .code6   (lut_code6),
    .dis6    (lut_dis6),
    .sel6    (lut_sel6),
    .code4   (lut_code4),
    .dis4    (lut_dis4),
    .sel4    (lut_sel4),
    .alt_neg (lut_alt_neg),
    .alt_pos (lut_alt_pos),
    .k_legal (lut_k_legal)
  );

  always_comb begin
    s1_next         = '0;
    s1_next.code6   = lut_code6;
    s1_next.dis6    = lut_dis6;
    s1_next.sel6    = lut_sel6;
    s1_next.code4   = lut_code4;
    s1_next.dis4    = lut_dis4;
    s1_next.sel4    = lut_sel4;
    s1_next.alt_neg = lut_alt_neg;
    s1_next.alt_pos = lut_alt_pos;
    s1_next.k_err   = is_control && !lut_k_legal;
    s1_next.valid   = data_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= '0;
    end else begin
      s1_reg <= s1_next;
    end
  end

  logic [SYM_W-1:0] symbol_reg;
  logic [SYM_W-1:0] symbol_next;
  logic             valid_reg;
  logic             k_err_reg;
  logic             rd_reg;
  logic             rd_next;
  logic             rd_mid;
  logic             use_alt;
  logic [5:0]       sym6;
  logic [3:0]       code4_pick;
  logic [3:0]       sym4;

  // Both sub-block polarity decisions resolve here in one cycle, so
  // back-to-back bytes never stall on the RD dependency.
  always_comb begin
    rd_mid      = rd_reg ^ s1_reg.dis6;
    sym6        = (s1_reg.sel6 && rd_reg) ? ~s1_reg.code6 : s1_reg.code6;
    use_alt     = rd_mid ? s1_reg.alt_pos : s1_reg.alt_neg;
    code4_pick  = use_alt ? ALT7_RDN : s1_reg.code4;
    sym4        = (s1_reg.sel4 && rd_mid) ? ~code4_pick : code4_pick;
    rd_next     = rd_mid ^ s1_reg.dis4;
    symbol_next = {sym6, sym4};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      symbol_reg <= '0;
      valid_reg  <= 1'b0;
      k_err_reg  <= 1'b0;
      rd_reg     <= INIT_RD;
    end else begin
      valid_reg <= s1_reg.valid;
      k_err_reg <= s1_reg.valid && s1_reg.k_err;
      if (s1_reg.valid) begin
        symbol_reg <= symbol_next;
        rd_reg     <= rd_next;
      end
    end
  end

  assign symbol       = symbol_reg;
  assign symbol_valid = valid_reg;
  assign rd_out       = rd_reg;
  assign k_err        = k_err_reg;

`ifdef ENC8B10B_STATS_EN
  logic [15:0] k_err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_err_cnt_reg <= '0;
    end else if (s1_reg.valid && s1_reg.k_err && (k_err_cnt_reg != 16'hFFFF)) begin
      k_err_cnt_reg <= k_err_cnt_reg + 16'd1;
    end
  end

  assign k_err_cnt = k_err_cnt_reg;
`endif

endmodule
